// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin, packet-locked arbiter that shares a single FIFO write port
// among NREQ requesters living in the write clock domain. Once a requester
// wins, it keeps the port until its last word (or until MAXPKT beats have
// moved), so packets never interleave inside the FIFO. An over-long packet
// is cut off, the sticky pkt_err flag is raised and the requester's leftover
// words compete again as a fresh packet.
//
// Ports
//   wclk       : write-domain clock, rising edge
//   wrst       : synchronous active-high reset
//   req_valid  : per-requester word valid                      [NREQ]
//   req_last   : per-requester last-word marker                [NREQ]
//   req_data   : flattened data, requester i at [i*DSIZE +: DSIZE]
//   req_ready  : per-requester accept                          [NREQ]
//   wfull      : registered FIFO full flag
//   winc       : FIFO write enable
//   wdata      : FIFO write data                               [DSIZE]
//   gnt_valid  : a grant is currently held
//   gnt_id     : current or most recent grantee                [IDW]
//   pkt_err    : sticky "packet exceeded MAXPKT beats" flag
//   err_clr    : clears pkt_err on the next edge
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DSIZE  = 8,
   parameter int MAXPKT = 16,
   parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    wclk,
   input  logic                    wrst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*DSIZE-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    wfull,
   output logic                    winc,
   output logic [DSIZE-1:0]        wdata,
   output logic                    gnt_valid,
   output logic [IDW-1:0]          gnt_id,
   output logic                    pkt_err,
   input  logic                    err_clr
);

   localparam int CW = $clog2(MAXPKT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_rrPtr;
   logic [IDW-1:0]   r_gntId;
   logic [CW-1:0]    r_beatCnt;
   logic             r_pktErr;

   state_t           w_nextState;
   logic [IDW-1:0]   w_nextRrPtr;
   logic [IDW-1:0]   w_nextGntId;
   logic [CW-1:0]    w_nextBeatCnt;
   logic             w_nextPktErr;

   logic             w_found;
   logic [IDW-1:0]   w_pick;
   logic             w_gValid;
   logic             w_gLast;
   logic [DSIZE-1:0] w_gData;
   logic             w_xfer;
   logic             w_atMax;
   logic [IDW-1:0]   w_afterGnt;

   // Round-robin search: first pass covers indices at or above rr_ptr,
   // second pass wraps around to the ones below it.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (IDW'(i) >= r_rrPtr)) begin
            w_found = 1'b1;
            w_pick  = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i]) begin
            w_found = 1'b1;
            w_pick  = IDW'(i);
         end
      end
   end

   // Select the granted requester's valid/last/data with constant indices.
   always_comb begin
      w_gValid = 1'b0;
      w_gLast  = 1'b0;
      w_gData  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gntId == IDW'(i)) begin
            w_gValid = req_valid[i];
            w_gLast  = req_last[i];
            w_gData  = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   // A beat moves only when the grantee offers a word and the FIFO has room.
   // wfull is registered by the FIFO and already accounts for prior writes.
   always_comb begin
      w_xfer     = (r_state == BUSY) && w_gValid && !wfull;
      w_atMax    = (int'(r_beatCnt) + 1 == MAXPKT);
      w_afterGnt = (r_gntId == IDW'(NREQ - 1)) ? '0 : r_gntId + 1'b1;
   end

   // Next-state logic. A forced release (MAXPKT reached without last) sets
   // the error flag; that set takes priority over a coincident err_clr.
   always_comb begin
      w_nextState   = r_state;
      w_nextRrPtr   = r_rrPtr;
      w_nextGntId   = r_gntId;
      w_nextBeatCnt = r_beatCnt;
      w_nextPktErr  = err_clr ? 1'b0 : r_pktErr;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nextState   = BUSY;
               w_nextGntId   = w_pick;
               w_nextBeatCnt = '0;
            end
         end
         BUSY: begin
            if (w_xfer) begin
               w_nextBeatCnt = r_beatCnt + CW'(1);
               if (w_gLast || w_atMax) begin
                  w_nextState = IDLE;
                  w_nextRrPtr = w_afterGnt;
               end
               if (w_atMax && !w_gLast) begin
                  w_nextPktErr = 1'b1;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register with synchronous reset; a reset mid-packet simply drops
   // the grant and the partial packet.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state   <= IDLE;
         r_rrPtr   <= '0;
         r_gntId   <= '0;
         r_beatCnt <= '0;
         r_pktErr  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_rrPtr   <= w_nextRrPtr;
         r_gntId   <= w_nextGntId;
         r_beatCnt <= w_nextBeatCnt;
         r_pktErr  <= w_nextPktErr;
      end
   end

   // Outputs are decoded from registered state; only the grantee sees ready.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if ((r_state == BUSY) && (r_gntId == IDW'(i)) && !wfull) begin
            req_ready[i] = 1'b1;
         end
      end
      winc      = w_xfer;
      wdata     = w_gData;
      gnt_valid = (r_state == BUSY);
      gnt_id    = r_gntId;
      pkt_err   = r_pktErr;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAXPKT=16). Inputs are
// driven just after the falling edge, outputs are sampled 1 time unit later,
// so each check sees the combinational outputs of the state held during that
// cycle. A stimulus table covers single packets, round-robin alternation and
// full-flag stalls; hand-written sequences cover long packets, error flag
// handling and reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NREQ   = 4;
   localparam int DSIZE  = 8;
   localparam int MAXPKT = 16;
   localparam int IDW    = 2;

   logic                  wclk;
   logic                  wrst;
   logic [NREQ-1:0]       reqValid;
   logic [NREQ-1:0]       reqLast;
   logic [NREQ*DSIZE-1:0] reqData;
   logic [NREQ-1:0]       reqReady;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  gntValid;
   logic [IDW-1:0]        gntId;
   logic                  pktErr;
   logic                  errClr;

   int vecCount;
   int missCount;

   typedef struct packed {
      logic        rst;
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic [31:0] data;
      logic        full;
      logic        clr;
      logic [3:0]  eRdy;
      logic        eWinc;
      logic [7:0]  eData;
      logic        eGv;
      logic [1:0]  eGid;
      logic        eErr;
   } vec_t;

   vec_t vecs[$];

   fifo_wr_arbiter #(
      .NREQ   (NREQ),
      .DSIZE  (DSIZE),
      .MAXPKT (MAXPKT),
      .IDW    (IDW)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (reqValid),
      .req_last  (reqLast),
      .req_data  (reqData),
      .req_ready (reqReady),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .gnt_valid (gntValid),
      .gnt_id    (gntId),
      .pkt_err   (pktErr),
      .err_clr   (errClr)
   );

   // Free-running write clock, period 10.
   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // Drive one cycle's worth of inputs shortly after the falling edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] vld,
                                input logic [3:0] lst, input logic [31:0] data,
                                input logic full, input logic clr);
      @(negedge wclk);
      wrst     = rst;
      reqValid = vld;
      reqLast  = lst;
      reqData  = data;
      wfull    = full;
      errClr   = clr;
      #1;
   endtask

   // Compare all outputs against the expected set; wdata only matters when
   // a write is expected.
   task automatic checkOutput(input string name, input logic [3:0] eRdy,
                              input logic eWinc, input logic [7:0] eData,
                              input logic eGv, input logic [1:0] eGid,
                              input logic eErr);
      logic bad;
      bad = (reqReady !== eRdy) || (winc !== eWinc) || (gntValid !== eGv) ||
            (gntId !== eGid) || (pktErr !== eErr) ||
            (eWinc && (wdata !== eData));
      vecCount++;
      if (bad) begin
         missCount++;
         $display("[TB] FAIL %s: got rdy=%b winc=%b wdata=%h gv=%b gid=%0d err=%b, expected rdy=%b winc=%b wdata=%h gv=%b gid=%0d err=%b",
                  name, reqReady, winc, wdata, gntValid, gntId, pktErr,
                  eRdy, eWinc, eData, eGv, eGid, eErr);
      end
   endtask

   task automatic addVec(input logic rst, input logic [3:0] vld,
                         input logic [3:0] lst, input logic [31:0] data,
                         input logic full, input logic clr,
                         input logic [3:0] eRdy, input logic eWinc,
                         input logic [7:0] eData, input logic eGv,
                         input logic [1:0] eGid, input logic eErr);
      vec_t v;
      v = '{rst, vld, lst, data, full, clr, eRdy, eWinc, eData, eGv, eGid, eErr};
      vecs.push_back(v);
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      wrst      = 1'b1;
      reqValid  = '0;
      reqLast   = '0;
      reqData   = '0;
      wfull     = 1'b0;
      errClr    = 1'b0;

      // Single 3-word packet from requester 0, then one idle bubble.
      addVec(0, 4'b0001, 4'b0000, 32'h000000A1, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      addVec(0, 4'b0001, 4'b0000, 32'h000000A1, 0, 0, 4'b0001, 1, 8'hA1, 1, 2'd0, 0);
      addVec(0, 4'b0001, 4'b0000, 32'h000000A2, 0, 0, 4'b0001, 1, 8'hA2, 1, 2'd0, 0);
      addVec(0, 4'b0001, 4'b0001, 32'h000000A3, 0, 0, 4'b0001, 1, 8'hA3, 1, 2'd0, 0);
      addVec(0, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      // Reset to bring rr_ptr back to 0.
      addVec(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      // Requesters 0 and 2 stream 2-word packets: grants 0,2,0,2.
      addVec(0, 4'b0101, 4'b0000, 32'h00200010, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00200010, 0, 0, 4'b0001, 1, 8'h10, 1, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0001, 32'h00200011, 0, 0, 4'b0001, 1, 8'h11, 1, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00200012, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00200012, 0, 0, 4'b0100, 1, 8'h20, 1, 2'd2, 0);
      addVec(0, 4'b0101, 4'b0100, 32'h00210012, 0, 0, 4'b0100, 1, 8'h21, 1, 2'd2, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00220012, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00220012, 0, 0, 4'b0001, 1, 8'h12, 1, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0001, 32'h00220013, 0, 0, 4'b0001, 1, 8'h13, 1, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00220014, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      addVec(0, 4'b0101, 4'b0000, 32'h00220014, 0, 0, 4'b0100, 1, 8'h22, 1, 2'd2, 0);
      addVec(0, 4'b0101, 4'b0100, 32'h00230014, 0, 0, 4'b0100, 1, 8'h23, 1, 2'd2, 0);
      addVec(0, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 0);
      // Requester 1 stalled by wfull for 4 cycles in the middle of a packet.
      addVec(0, 4'b0010, 4'b0000, 32'h00003000, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003000, 0, 0, 4'b0010, 1, 8'h30, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003100, 1, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003100, 1, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003100, 1, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003100, 1, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0000, 32'h00003100, 0, 0, 4'b0010, 1, 8'h31, 1, 2'd1, 0);
      addVec(0, 4'b0010, 4'b0010, 32'h00003200, 0, 0, 4'b0010, 1, 8'h32, 1, 2'd1, 0);
      addVec(0, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd1, 0);

      // Initial reset and reset-state check.
      applyStimulus(1, 4'b0000, 4'b0000, 32'h0, 0, 0);
      applyStimulus(1, 4'b0000, 4'b0000, 32'h0, 0, 0);
      applyStimulus(0, 4'b0000, 4'b0000, 32'h0, 0, 0);
      checkOutput("reset_state", 4'b0000, 0, 8'h00, 0, 2'd0, 0);

      foreach (vecs[n]) begin
         applyStimulus(vecs[n].rst, vecs[n].vld, vecs[n].lst, vecs[n].data,
                       vecs[n].full, vecs[n].clr);
         checkOutput($sformatf("vec%0d", n), vecs[n].eRdy, vecs[n].eWinc,
                     vecs[n].eData, vecs[n].eGv, vecs[n].eGid, vecs[n].eErr);
      end

      // Requester 3 offers 20 words with no last: 16 beats, forced release,
      // then the remaining 4 go out under a new grant.
      applyStimulus(0, 4'b1000, 4'b0000, 32'h40000000, 0, 0);
      checkOutput("long_arb", 4'b0000, 0, 8'h00, 0, 2'd1, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 4'b1000, 4'b0000, {8'(8'h40 + i), 24'h0}, 0, 0);
         checkOutput($sformatf("long_beat%0d", i), 4'b1000, 1, 8'(8'h40 + i), 1, 2'd3, 0);
      end
      applyStimulus(0, 4'b1000, 4'b0000, 32'h50000000, 0, 0);
      checkOutput("forced_release", 4'b0000, 0, 8'h00, 0, 2'd3, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 4'b1000, (i == 3) ? 4'b1000 : 4'b0000,
                       {8'(8'h50 + i), 24'h0}, 0, 0);
         checkOutput($sformatf("tail_beat%0d", i), 4'b1000, 1, 8'(8'h50 + i), 1, 2'd3, 1);
      end

      // One-word packet from requester 1 leaves rr_ptr at 2.
      applyStimulus(0, 4'b0010, 4'b0010, 32'h00006000, 0, 0);
      checkOutput("short_arb", 4'b0000, 0, 8'h00, 0, 2'd3, 1);
      applyStimulus(0, 4'b0010, 4'b0010, 32'h00006000, 0, 0);
      checkOutput("short_beat", 4'b0010, 1, 8'h60, 1, 2'd1, 1);

      // Reset after beat 5 of a requester-3 packet.
      applyStimulus(0, 4'b1000, 4'b0000, 32'h70000000, 0, 0);
      checkOutput("rst_arb", 4'b0000, 0, 8'h00, 0, 2'd1, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 4'b1000, 4'b0000, {8'(8'h70 + i), 24'h0}, 0, 0);
         checkOutput($sformatf("rst_beat%0d", i), 4'b1000, 1, 8'(8'h70 + i), 1, 2'd3, 1);
      end
      applyStimulus(1, 4'b1010, 4'b0010, 32'h75008000, 0, 0);
      applyStimulus(0, 4'b1010, 4'b0010, 32'h75008000, 0, 0);
      checkOutput("after_reset", 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      applyStimulus(0, 4'b1010, 4'b0010, 32'h75008000, 0, 0);
      checkOutput("post_reset_grant", 4'b0010, 1, 8'h80, 1, 2'd1, 0);

      // err_clr coinciding with a forced release: set wins.
      applyStimulus(0, 4'b0010, 4'b0000, 32'h00009000, 0, 0);
      checkOutput("clr_arb", 4'b0000, 0, 8'h00, 0, 2'd1, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 4'b0010, 4'b0000, {16'h0, 8'(8'h90 + i), 8'h0}, 0, (i == 15));
         checkOutput($sformatf("clr_beat%0d", i), 4'b0010, 1, 8'(8'h90 + i), 1, 2'd1, 0);
      end
      applyStimulus(0, 4'b0000, 4'b0000, 32'h0, 0, 1);
      checkOutput("set_wins", 4'b0000, 0, 8'h00, 0, 2'd1, 1);
      applyStimulus(0, 4'b0000, 4'b0000, 32'h0, 0, 0);
      checkOutput("clr_alone", 4'b0000, 0, 8'h00, 0, 2'd1, 0);

      // Exactly MAXPKT beats with last on the final beat is legal.
      applyStimulus(0, 4'b0001, 4'b0000, 32'h000000B0, 0, 0);
      checkOutput("max_arb", 4'b0000, 0, 8'h00, 0, 2'd1, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 4'b0001, (i == 15) ? 4'b0001 : 4'b0000,
                       {24'h0, 8'(8'hB0 + i)}, 0, 0);
         checkOutput($sformatf("max_beat%0d", i), 4'b0001, 1, 8'(8'hB0 + i), 1, 2'd0, 0);
      end
      applyStimulus(0, 4'b0000, 4'b0000, 32'h0, 0, 0);
      checkOutput("max_legal", 4'b0000, 0, 8'h00, 0, 2'd0, 0);
      applyStimulus(0, 4'b0000, 4'b0000, 32'h0, 0, 0);
      checkOutput("max_legal_hold", 4'b0000, 0, 8'h00, 0, 2'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one asynchronous FIFO write port among NREQ requesters in the write clock domain.
- Drives the FIFO winc/wdata pair and obeys the FIFO's registered wfull flag.
- Keeps each packet contiguous in the FIFO: once a requester holds the grant, no other requester's words are interleaved until its last word.
- Enforces a maximum packet length and flags violations.

Parameters:
- NREQ, 4, number of requesters (≥1).
- DSIZE, 8, FIFO data width in bits.
- MAXPKT, 16, maximum beats per packet before a forced grant release (≥1).
- IDW, $clog2(NREQ) (minimum 1), width of the grant index.

Ports:
- wclk  in  1  write-domain clock; all state changes on the rising edge.
- wrst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester word valid.
- req_last  in  NREQ  per-requester last-word-of-packet marker; qualified by req_valid.
- req_data  in  NREQ*DSIZE  flattened data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both high.
- wfull  in  1  FIFO full flag, registered by the FIFO.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- gnt_valid  out  1  a grant is held (state BUSY).
- gnt_id  out  IDW  index of the current or most recent grantee.
- pkt_err  out  1  sticky flag: a packet exceeded MAXPKT beats.
- err_clr  in  1  clears pkt_err.

Behaviour:
- Reset (wrst=1 at a wclk edge):
  - state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0, pkt_err=0.
  - Consequently gnt_valid=0, winc=0, req_ready=0.
  - Reset during BUSY abandons the packet immediately; no partial-packet recovery.
- State machine, two states: IDLE and BUSY.
- IDLE:
  - If any req_valid bit is set, select the first asserted requester in order rr_ptr, rr_ptr+1, … (mod NREQ).
  - Register it into gnt_id, clear beat_cnt, and go to BUSY on the next edge.
  - No transfer happens in the arbitration cycle, so the first word of a packet has 1-cycle latency.
  - If no requester is valid, stay in IDLE.
- BUSY, outputs (combinational from registered state):
  - req_ready[gnt_id] = ~wfull. All other req_ready bits = 0.
  - winc = req_valid[gnt_id] & ~wfull.
  - wdata = req_data[gnt_id] (don't-care when winc=0).
- BUSY, on each transfer:
  - beat_cnt increments.
  - If req_last[gnt_id]=1, or beat_cnt+1 == MAXPKT: go to IDLE and set rr_ptr = (gnt_id+1) mod NREQ.
  - The MAXPKT exit with req_last=0 is a forced release and sets pkt_err. The requester's remaining words re-arbitrate as a new packet.
  - A packet of exactly MAXPKT beats ending with req_last=1 is legal; no error.
- BUSY, no transfer:
  - wfull=1: stall, winc=0.
  - req_valid[gnt_id]=0 mid-packet: hold the grant indefinitely. No timeout, no preemption.
- gnt_valid = (state==BUSY).
- gnt_id holds its value in IDLE.
- Width rules:
  - beat_cnt is $clog2(MAXPKT+1) bits and never wraps.
  - rr_ptr wraps from NREQ-1 to 0; for non-power-of-2 NREQ it never takes the value NREQ.
- Fairness and throughput:
  - Each packet is followed by one IDLE bubble.
  - A requester that has just finished becomes lowest priority, so any continuously requesting source waits at most NREQ-1 packets.
- pkt_err:
  - err_clr=1 clears it on the next edge.
  - If err_clr coincides with a new forced release, set wins (pkt_err=1).
- wfull safety:
  - wfull is registered and already reflects the pending write, so winc is never asserted while wfull=1.
  - No write is ever lost, and no write occurs while the FIFO is full.
- NREQ=1: degenerates to a packet framer with MAXPKT checking; rr_ptr stays 0.

Test Plan:
- Reset, then only req0 valid with a 3-word packet (A1,A2,A3, last on A3), wfull=0 → gnt_id=0; winc high for 3 consecutive cycles starting 1 cycle after valid; wdata=A1,A2,A3; then gnt_valid=0 for 1 cycle.
- req0 and req2 each continuously send 2-word packets from reset → grant order 0,2,0,2; FIFO data never interleaves within a packet; one bubble between packets.
- BUSY on req1, wfull=1 for 4 cycles mid-packet → winc=0 and req_ready[1]=0 during those cycles; transfers resume the cycle wfull=0; word count and order intact.
- MAXPKT=16, req3 sends 20 words with no last → winc for 16 beats, forced release, pkt_err=1; after re-arbitration the remaining 4 words transfer as a new grant; a 16-beat packet with last on beat 16 leaves pkt_err=0.
- err_clr=1 in the same cycle as a forced release → pkt_err=1; err_clr=1 alone on the next cycle → pkt_err=0.
- wrst=1 asserted mid-packet (after beat 5) → next cycle gnt_valid=0, winc=0, pkt_err=0, rr_ptr=0; the next arbitration picks the lowest-index valid requester.
